// File: rtl/placar_ataque.sv
// ----------------------------------------------------------------------------
// placar_ataque -- scoreboard and turn controller for the attack phase.
//
// Takes the sticky 5-bit hit flags from the attack-verification stage after
// every shot. It decides whether the shot was a hit or a miss, counts hits and
// remaining shots, and declares a win or a loss. Every output is registered.
//
// Parameters:
//   MAX_SHOTS  shots granted per game (1..15)
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset (wins over every input)
//   start       in   begin a new game (honoured in IDLE, WIN, LOSE)
//   ship_mask   in   [4:0] map occupancy, captured on an accepted start
//   shot_valid  in   single-cycle fire pulse (honoured in READY only)
//   hit_flags   in   [4:0] sticky hit flags from the verification stage
//   ready       out  high while in READY
//   hit_pulse   out  one-cycle pulse: the shot produced at least one new hit
//   miss_pulse  out  one-cycle pulse: the shot produced no new hit
//   hits        out  [2:0] ship positions hit so far
//   shots_left  out  [3:0] shots remaining
//   win         out  high while in WIN
//   lose        out  high while in LOSE
//
// Shot handshake: a shot is accepted when shot_valid is high at a rising edge
// while ready is high. There is no back-pressure toward the source. A
// shot_valid seen while ready is low is dropped: it is neither queued nor
// counted. After acceptance, hit_flags is sampled one edge later (EVAL).
// Results (pulses, counters, win/lose) are visible after that second edge.
//
// Optional feature macro: PLACAR_BONUS_SHOT_EN
//   When defined, a shot that produces a new hit does not consume a shot.
//   Only misses decrement shots_left.
// ----------------------------------------------------------------------------
module placar_ataque #(
  parameter int MAX_SHOTS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] ship_mask,
  input  logic       shot_valid,
  input  logic [4:0] hit_flags,
  output logic       ready,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic [2:0] hits,
  output logic [3:0] shots_left,
  output logic       win,
  output logic       lose
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_EVAL  = 3'd2,
    S_WIN   = 3'd3,
    S_LOSE  = 3'd4
  } state_t;

  localparam logic [3:0] MAX_SHOTS_L = 4'(MAX_SHOTS);

  function automatic logic [2:0] popcount5(input logic [4:0] v);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < 5; i++) begin
      c = c + {2'b00, v[i]};
    end
    return c;
  endfunction

  state_t     state_q, state_d;
  logic [4:0] mask_q, mask_d;
  logic [2:0] total_q, total_d;
  logic [4:0] prev_q, prev_d;
  logic [2:0] hits_q, hits_d;
  logic [3:0] shots_left_q, shots_left_d;
  logic       ready_q, ready_d;
  logic       hit_pulse_q, hit_pulse_d;
  logic       miss_pulse_q, miss_pulse_d;
  logic       win_q, win_d;
  logic       lose_q, lose_d;

  logic [4:0] new_bits;
  logic [2:0] init_total;

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    total_d      = total_q;
    prev_d       = prev_q;
    hits_d       = hits_q;
    shots_left_d = shots_left_q;
    hit_pulse_d  = 1'b0;
    miss_pulse_d = 1'b0;
    // Positions newly hit on this shot: must be a ship and not counted yet.
    new_bits     = hit_flags & mask_q & ~prev_q;
    init_total   = popcount5(ship_mask);

    unique case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start) begin
          mask_d       = ship_mask;
          total_d      = init_total;
          // Flags already set at game start are taken as the baseline, so
          // they never score in this game.
          prev_d       = hit_flags & ship_mask;
          hits_d       = 3'd0;
          shots_left_d = MAX_SHOTS_L;
          state_d      = (init_total == 3'd0) ? S_WIN : S_READY;
        end
      end

      S_READY: begin
        if (shot_valid) begin
          state_d = S_EVAL;
        end
      end

      S_EVAL: begin
        if (new_bits != 5'd0) begin
          hit_pulse_d = 1'b1;
          hits_d      = hits_q + popcount5(new_bits);
          prev_d      = prev_q | new_bits;
`ifdef PLACAR_BONUS_SHOT_EN
          shots_left_d = shots_left_q;
`else
          shots_left_d = shots_left_q - 4'd1;
`endif
        end else begin
          miss_pulse_d = 1'b1;
          shots_left_d = shots_left_q - 4'd1;
        end
        // A win on the last shot takes priority over running out of shots.
        if (hits_d == total_q) begin
          state_d = S_WIN;
        end else if (shots_left_d == 4'd0) begin
          state_d = S_LOSE;
        end else begin
          state_d = S_READY;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Status flags are registered copies of the next state.
    ready_d = (state_d == S_READY);
    win_d   = (state_d == S_WIN);
    lose_d  = (state_d == S_LOSE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mask_q       <= 5'd0;
      total_q      <= 3'd0;
      prev_q       <= 5'd0;
      hits_q       <= 3'd0;
      shots_left_q <= 4'd0;
      ready_q      <= 1'b0;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
      win_q        <= 1'b0;
      lose_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      total_q      <= total_d;
      prev_q       <= prev_d;
      hits_q       <= hits_d;
      shots_left_q <= shots_left_d;
      ready_q      <= ready_d;
      hit_pulse_q  <= hit_pulse_d;
      miss_pulse_q <= miss_pulse_d;
      win_q        <= win_d;
      lose_q       <= lose_d;
    end
  end

  assign ready      = ready_q;
  assign hit_pulse  = hit_pulse_q;
  assign miss_pulse = miss_pulse_q;
  assign hits       = hits_q;
  assign shots_left = shots_left_q;
  assign win        = win_q;
  assign lose       = lose_q;

endmodule
